// File: rtl/transconv_pkg.sv
// Shared types and helpers for the stride-2 3x3 transposed-convolution stream.
package transconv_pkg;
  localparam int K      = 3;
  localparam int STRIDE = 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FLUSH} state_t;

  // Logical row roles: A = out row 2iy, B = 2iy+1, C = 2iy+2.
  typedef enum logic [1:0] {ROLE_A = 2'd0, ROLE_B = 2'd1, ROLE_C = 2'd2} role_t;

  function automatic logic [1:0] phys_row(input logic [1:0] rot, input logic [1:0] role);
    logic [2:0] s;
    s = {1'b0, rot} + {1'b0, role};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/transconv_requant.sv
// Combinational requantizer: bias add, round-half-up shift, optional ReLU, saturate.
module transconv_requant
  import transconv_pkg::*;
#(
  parameter int ACC_W  = 20,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 8
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic signed [BIAS_W-1:0] i_bias,
  input  logic [3:0]               i_shift,
  input  logic                     i_relu,
  output logic [OUT_W-1:0]         o_data
);
  logic signed [31:0] w_sum, w_rnd, w_shf, w_relu, w_sat;

  always_comb begin
    w_sum  = 32'(i_acc) + 32'(i_bias);
    w_rnd  = (i_shift != 4'd0) ? w_sum + (32'sd1 <<< (i_shift - 4'd1)) : w_sum;
    w_shf  = w_rnd >>> i_shift;
    w_relu = (i_relu && (w_shf < 0)) ? 32'sd0 : w_shf;
    w_sat  = saturate(w_relu, OUT_W);
  end

  assign o_data = OUT_W'(w_sat);
endmodule

// File: rtl/transconv_stream.sv
// Streaming 3x3 stride-2 transposed convolution: scatter-accumulate into three
// rotating row buffers, then drain rows through a requant + output register.
module transconv_stream
  import transconv_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter int BIAS_W   = 16,
  parameter int OUT_W    = 8,
  parameter int MAX_IN_W = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            cfg_in_w,
  input  logic [7:0]            cfg_in_h,
  input  logic [3:0]            cfg_shift,
  input  logic                  cfg_relu,
  input  logic [9*DATA_W-1:0]   weights,
  input  logic [BIAS_W-1:0]     bias,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_eol,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int BUF_N = 2*MAX_IN_W + 1;
  localparam int CW    = $clog2(BUF_N);

  state_t r_state, w_state_nxt;
  logic [7:0] r_w, r_h, r_ix, r_iy;
  logic [3:0] r_shift;
  logic       r_relu, r_rsel, r_done;
  logic [1:0] r_rot;
  logic [CW-1:0] r_col;
  logic signed [DATA_W-1:0] r_wt [9];
  logic signed [BIAS_W-1:0] r_bias;
  logic signed [ACC_W-1:0]  r_buf [3][BUF_N];
  logic r_out_valid, r_out_eol, r_out_last;
  logic [OUT_W-1:0] r_out_data;

  logic w_cfg_zero, w_in_hs, w_adv, w_out_hs, w_rd, w_row_end, w_last_ix, w_last_iy;
  logic [CW-1:0] w_w2, w_col0;
  logic [1:0] w_rd_row;
  logic signed [ACC_W-1:0] w_rd_acc;
  logic signed [ACC_W-1:0] w_prod [9];
  logic [OUT_W-1:0] w_q;

  assign w_cfg_zero = (cfg_in_w == 8'd0) || (cfg_in_h == 8'd0);
  assign w_in_hs    = (r_state == ACCUM) && in_valid;
  assign w_adv      = !r_out_valid || out_ready;
  assign w_out_hs   = r_out_valid && out_ready;
  // Once the frame's last pixel is registered, FLUSH stops reading until it is taken.
  assign w_rd       = w_adv && ((r_state == DRAIN) || ((r_state == FLUSH) && !r_out_last));
  assign w_w2       = CW'({r_w, 1'b0});
  assign w_col0     = CW'({r_ix, 1'b0});
  assign w_row_end  = (r_col == w_w2);
  assign w_last_ix  = (r_ix == r_w - 8'd1);
  assign w_last_iy  = (r_iy == r_h - 8'd1);
  assign w_rd_row   = phys_row(r_rot, (r_state == FLUSH) ? ROLE_C : (r_rsel ? ROLE_B : ROLE_A));
  assign w_rd_acc   = r_buf[w_rd_row][r_col];

  always_comb begin
    for (int k = 0; k < 9; k++)
      w_prod[k] = ACC_W'($signed(in_data)) * ACC_W'(r_wt[k]);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start && !w_cfg_zero) w_state_nxt = ACCUM;
      ACCUM:   if (w_in_hs && w_last_ix) w_state_nxt = DRAIN;
      DRAIN:   if (w_rd && w_row_end && r_rsel) w_state_nxt = w_last_iy ? FLUSH : ACCUM;
      FLUSH:   if (w_out_hs && r_out_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;

  // Read-modify-write scatter; column 2ix+2 is visible to pixel ix+1 next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < BUF_N; c++) r_buf[r][c] <= '0;
    end else if (w_in_hs) begin
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          r_buf[phys_row(r_rot, 2'(ky))][w_col0 + CW'(kx)] <=
            r_buf[phys_row(r_rot, 2'(ky))][w_col0 + CW'(kx)] + w_prod[ky*K + kx];
    end else if (w_rd) begin
      r_buf[w_rd_row][r_col] <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w <= '0; r_h <= '0; r_ix <= '0; r_iy <= '0; r_shift <= '0; r_relu <= 1'b0;
      r_rsel <= 1'b0; r_rot <= '0; r_col <= '0; r_bias <= '0; r_done <= 1'b0;
      for (int k = 0; k < 9; k++) r_wt[k] <= '0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == IDLE) && start) begin
        r_w <= cfg_in_w; r_h <= cfg_in_h; r_shift <= cfg_shift; r_relu <= cfg_relu;
        r_bias <= $signed(bias);
        for (int k = 0; k < 9; k++) r_wt[k] <= $signed(weights[k*DATA_W +: DATA_W]);
        r_ix <= '0; r_iy <= '0; r_col <= '0; r_rsel <= 1'b0; r_rot <= '0;
        r_done <= w_cfg_zero;
      end
      if (w_in_hs) r_ix <= w_last_ix ? 8'd0 : r_ix + 8'd1;
      if (w_rd) begin
        if (w_row_end) begin
          r_col <= '0;
          if (r_state == DRAIN) begin
            r_rsel <= !r_rsel;
            // Rotate roles: C becomes the new A, the drained rows become B and C.
            if (r_rsel && !w_last_iy) begin
              r_rot <= phys_row(r_rot, ROLE_C);
              r_iy  <= r_iy + 8'd1;
            end
          end
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_out_hs && r_out_last) r_done <= 1'b1;
    end
  end

  transconv_requant #(.ACC_W(ACC_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) u_requant (
    .i_acc(w_rd_acc), .i_bias(r_bias), .i_shift(r_shift), .i_relu(r_relu), .o_data(w_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0; r_out_data <= '0; r_out_eol <= 1'b0; r_out_last <= 1'b0;
    end else if (w_rd) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_q;
      r_out_eol   <= w_row_end;
      r_out_last  <= (r_state == FLUSH) && w_row_end;
    end else if (out_ready) begin
      r_out_valid <= 1'b0; r_out_eol <= 1'b0; r_out_last <= 1'b0;
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_eol   = r_out_eol;
  assign out_last  = r_out_last;
endmodule
